// File: rtl/sort_ctrl_pkg.sv
// Shared types and defaults for the UART-fed sort sequencer.
// Optional feature macro: SORT_CKSUM_EN (XOR checksum byte after each sequence).
package sort_ctrl_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_NUM_SEQ = 10;

  localparam int BYTES_PER_WORD = DEF_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_SORT,
    ST_SEND
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_word_pack.sv
// Byte-to-key packer: drops each received byte into its key slot, MSB first.
// Optional feature macro: SORT_CKSUM_EN (not used here).
import sort_ctrl_pkg::*;

module sort_word_pack #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BPW   = BYTES_PER_WORD,
  parameter int KW    = idx_w(DEF_DEPTH),
  parameter int BW    = idx_w(BYTES_PER_WORD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [KW-1:0]          key_idx,
  input  logic [BW-1:0]          byte_idx,
  input  logic [7:0]             byte_in,
  output logic [WIDTH*DEPTH-1:0] keys
);

  logic [WIDTH*DEPTH-1:0] keys_q, keys_d;

  always_comb begin
    keys_d = keys_q;
    if (wr) begin
      keys_d[int'(key_idx)*WIDTH + (BPW-1-int'(byte_idx))*8 +: 8] = byte_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) keys_q <= '0;
    else     keys_q <= keys_d;
  end

  assign keys = keys_q;

endmodule

// File: rtl/sort_seq_ctrl.sv
// Receive DEPTH keys over UART, launch the sorter, stream sorted keys back.
// Optional feature macro: SORT_CKSUM_EN (append XOR of sent data bytes).
import sort_ctrl_pkg::*;

module sort_seq_ctrl #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_SEQ = DEF_NUM_SEQ
) (
  input  logic                         CLK100MHZ,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         sort_start,
  output logic [WIDTH*DEPTH-1:0]       sort_in,
  input  logic                         sort_done,
  input  logic [WIDTH*DEPTH-1:0]       sort_out,
  output logic [$clog2(NUM_SEQ+1)-1:0] seq_cnt,
  output logic                         batch_done,
  output logic                         overrun,
  output logic                         rx_led,
  output logic                         tx_led
);

  localparam int BPW = WIDTH / 8;
  localparam int KW  = idx_w(DEPTH);
  localparam int BW  = idx_w(BPW);
  localparam int CW  = $clog2(NUM_SEQ+1);
  localparam int N   = WIDTH * DEPTH;

  state_e         state_q, state_d;
  logic [KW-1:0]  key_q, key_d, nxt_key, wr_key;
  logic [BW-1:0]  byte_q, byte_d, nxt_byte, wr_byte;
  logic [N-1:0]   res_q, res_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           start_q, start_d;
  logic [CW-1:0]  seq_q, seq_d;
  logic           batch_q, batch_d;
  logic           ovr_q, ovr_d;
  logic           wr, done, last_byte, last_key;

`ifdef SORT_CKSUM_EN
  logic [7:0]     cks_q, cks_d;
  logic           ckp_q, ckp_d;
`endif

  function automatic logic [7:0] pick(
    input logic [N-1:0]  src,
    input logic [KW-1:0] k,
    input logic [BW-1:0] b
  );
    return src[int'(k)*WIDTH + (BPW-1-int'(b))*8 +: 8];
  endfunction

  assign last_byte = (byte_q == BW'(BPW-1));
  assign last_key  = (key_q == KW'(DEPTH-1));
  assign nxt_byte  = last_byte ? '0 : byte_q + 1'b1;
  assign nxt_key   = last_byte ? key_q + 1'b1 : key_q;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    byte_d     = byte_q;
    res_d      = res_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    start_d    = 1'b0;
    seq_d      = seq_q;
    batch_d    = 1'b0;
    ovr_d      = ovr_q;
    wr         = 1'b0;
    wr_key     = key_q;
    wr_byte    = byte_q;
    done       = 1'b0;
`ifdef SORT_CKSUM_EN
    cks_d      = cks_q;
    ckp_d      = ckp_q;
`endif
    if (rx_valid && (state_q == ST_SORT || state_q == ST_SEND)) ovr_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          wr      = 1'b1;
          wr_key  = '0;
          wr_byte = '0;
          byte_d  = (BPW > 1) ? BW'(1) : '0;
          key_d   = (BPW > 1) ? '0 : KW'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          wr = 1'b1;
          if (last_key && last_byte) begin
            state_d = ST_SORT;
            start_d = 1'b1;
          end else begin
            key_d  = nxt_key;
            byte_d = nxt_byte;
          end
        end
      end
      ST_SORT: begin
        if (sort_done) begin
          res_d      = sort_out;
          key_d      = '0;
          byte_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = pick(sort_out, '0, '0);
          state_d    = ST_SEND;
`ifdef SORT_CKSUM_EN
          cks_d      = '0;
          ckp_d      = 1'b0;
`endif
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
`ifdef SORT_CKSUM_EN
          if (ckp_q) begin
            done = 1'b1;
          end else begin
            cks_d = cks_q ^ tx_data_q;
            if (last_key && last_byte) begin
              ckp_d     = 1'b1;
              tx_data_d = cks_q ^ tx_data_q;
            end else begin
              key_d     = nxt_key;
              byte_d    = nxt_byte;
              tx_data_d = pick(res_q, nxt_key, nxt_byte);
            end
          end
`else
          if (last_key && last_byte) begin
            done = 1'b1;
          end else begin
            key_d     = nxt_key;
            byte_d    = nxt_byte;
            tx_data_d = pick(res_q, nxt_key, nxt_byte);
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Final byte accepted: close the sequence and advance the batch count.
    if (done) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      key_d      = '0;
      byte_d     = '0;
      if (seq_q == CW'(NUM_SEQ-1)) begin
        seq_d   = '0;
        batch_d = 1'b1;
      end else begin
        seq_d = seq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      byte_q     <= '0;
      res_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      seq_q      <= '0;
      batch_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      byte_q     <= byte_d;
      res_q      <= res_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      start_q    <= start_d;
      seq_q      <= seq_d;
      batch_q    <= batch_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef SORT_CKSUM_EN
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      cks_q <= '0;
      ckp_q <= 1'b0;
    end else begin
      cks_q <= cks_d;
      ckp_q <= ckp_d;
    end
  end
`endif

  sort_word_pack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BPW   (BPW),
    .KW    (KW),
    .BW    (BW)
  ) u_pack (
    .clk      (CLK100MHZ),
    .rst      (rst),
    .wr       (wr),
    .key_idx  (wr_key),
    .byte_idx (wr_byte),
    .byte_in  (rx_data),
    .keys     (sort_in)
  );

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign sort_start = start_q;
  assign seq_cnt    = seq_q;
  assign batch_done = batch_q;
  assign overrun    = ovr_q;
  assign rx_led     = (state_q == ST_RECV);
  assign tx_led     = (state_q == ST_SEND);

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl with a behavioural sorter model.
// Define SORT_CKSUM_EN to expect the trailing checksum byte.
module tb_sort_seq_ctrl;

  localparam int W   = 32;
  localparam int D   = 8;
  localparam int NS  = 10;
  localparam int BPW = W / 8;
  localparam int CW  = $clog2(NS+1);

  typedef logic [W-1:0] keys_t [D];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           sort_start;
  logic [W*D-1:0] sort_in;
  logic           sort_done = 1'b0;
  logic [W*D-1:0] sort_out = '0;
  logic [CW-1:0]  seq_cnt;
  logic           batch_done, overrun, rx_led, tx_led;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int batches = 0;
  logic [7:0]     exp_q [$];
  logic [W*D-1:0] exp_in = '0;

  sort_seq_ctrl #(.WIDTH(W), .DEPTH(D), .NUM_SEQ(NS)) dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sort_start (sort_start),
    .sort_in    (sort_in),
    .sort_done  (sort_done),
    .sort_out   (sort_out),
    .seq_cnt    (seq_cnt),
    .batch_done (batch_done),
    .overrun    (overrun),
    .rx_led     (rx_led),
    .tx_led     (tx_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic keys_t sort_keys(input keys_t k);
    keys_t s = k;
    logic [W-1:0] t;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D-1-i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s;
  endfunction

  function automatic logic [W*D-1:0] pack(input keys_t k);
    logic [W*D-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = k[i];
    return v;
  endfunction

  function automatic keys_t unpack(input logic [W*D-1:0] v);
    keys_t k;
    for (int i = 0; i < D; i++) k[i] = v[i*W +: W];
    return k;
  endfunction

  // Sorter model: answers each launch a few cycles later.
  initial forever begin
    @(negedge clk);
    if (sort_start && !rst) begin
      starts++;
      chk("sort_in", sort_in, exp_in);
      repeat (3) @(posedge clk);
      #1;
      sort_out  = pack(sort_keys(unpack(sort_in)));
      sort_done = 1'b1;
      chk("sort_in_hold", sort_in, exp_in);
      @(posedge clk);
      #1 sort_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (batch_done) batches++;
    if (tx_valid) begin
      chk("txv_in_send", tx_led, 1);
      if (tx_ready) begin
        chk("tx_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic rx_put(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic rx_idle();
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_txv"}, tx_valid, 0);
    chk({tag, "_start"}, sort_start, 0);
    chk({tag, "_sort_in"}, sort_in, 0);
    chk({tag, "_seq"}, seq_cnt, 0);
    chk({tag, "_batch"}, batch_done, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_rxled"}, rx_led, 0);
    chk({tag, "_txled"}, tx_led, 0);
  endtask

  // mode 0: plain, 1: tx_ready stall, 2: rx byte during SORT
  task automatic run_seq(input keys_t k, input int mode, input int nseq);
    keys_t s = sort_keys(k);
    logic [7:0] cks = '0;
    logic [7:0] b1, d0;
    int st0 = starts;
    int c;
    for (int i = 0; i < D; i++)
      for (int b = 0; b < BPW; b++) begin
        exp_q.push_back(s[i][W-1-8*b -: 8]);
        cks ^= s[i][W-1-8*b -: 8];
      end
`ifdef SORT_CKSUM_EN
    exp_q.push_back(cks);
`endif
    b1 = s[0][W-9 -: 8];
    exp_in = pack(k);
    if (mode == 1) tx_ready = 1'b0;
    for (int i = 0; i < D; i++)
      for (int b = 0; b < BPW; b++) rx_put(k[i][W-1-8*b -: 8]);
    if (mode == 2) begin
      @(posedge clk);
      #1;
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
    end
    rx_idle();
    if (mode == 1) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!tx_valid && c < 100);
      chk("stall_txv", tx_valid, 1);
      d0 = tx_data;
      repeat (4) begin
        @(negedge clk);
        chk("stall_txv_hold", tx_valid, 1);
        chk("stall_txd_hold", tx_data, d0);
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(negedge clk);
      chk("next_txv", tx_valid, 1);
      chk("next_txd", tx_data, b1);
      @(posedge clk);
      #1 tx_ready = 1'b1;
    end
    c = 0;
    while ((exp_q.size() != 0 || tx_led) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("seq_drain", exp_q.size(), 0);
    @(negedge clk);
    chk("starts", starts - st0, 1);
    chk("seq_cnt", seq_cnt, nseq);
    if (mode == 2) chk("overrun_set", overrun, 1);
  endtask

  initial begin
    keys_t k;
    #2;
    outs_zero("rst0");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < D; i++) k[i] = W'(D - i);
    run_seq(k, 0, 1);
    chk("overrun_clear", overrun, 0);
    run_seq(k, 1, 2);
    for (int i = 0; i < D; i++) k[i] = $urandom;
    run_seq(k, 2, 3);
    for (int n = 4; n <= NS; n++) begin
      for (int i = 0; i < D; i++) k[i] = $urandom;
      run_seq(k, 0, n % NS);
    end
    chk("batch_once", batches, 1);

    for (int i = 0; i < 17; i++) rx_put(8'(i + 8'h30));
    #2;
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    outs_zero("rst_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < D; i++) k[i] = $urandom_range(1000, 1);
    run_seq(k, 0, 1);
    chk("batch_total", batches, 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: key width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8: keys per sequence, a power of 2 and at least 2.
REQ-003 SHALL have parameter NUM_SEQ, default 10: sequences per batch.
REQ-004 SHALL have ports, clock and reset first:
- CLK100MHZ  in  1  100 MHz clock, the only clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  1-cycle strobe qualifying rx_data.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte.
- sort_start  out  1  1-cycle sorter launch.
- sort_in  out  WIDTH*DEPTH  packed keys; key 0 in the LSBs.
- sort_done  in  1  1-cycle sorter completion strobe.
- sort_out  in  WIDTH*DEPTH  sorted keys; key 0 in the LSBs.
- seq_cnt  out  $clog2(NUM_SEQ+1)  sequences completed in the current batch.
- batch_done  out  1  1-cycle pulse when the NUM_SEQ-th sequence finishes.
- overrun  out  1  sticky flag: an rx byte was dropped.
- rx_led  out  1  high in state RECV.
- tx_led  out  1  high in state SEND.

Function
REQ-005 SHALL implement the states IDLE, RECV, SORT and SEND.
REQ-006 Transitions SHALL be:
- IDLE to RECV on rx_valid.
- RECV to SORT after the last byte of key DEPTH-1.
- SORT to SEND on sort_done.
- SEND to IDLE after the last byte is accepted.
REQ-007 The IDLE-to-RECV byte SHALL be stored as byte 0 of key 0.
REQ-008 Key assembly SHALL be MSB-first: WIDTH/8 bytes per key, keys 0 through DEPTH-1 in arrival order.
REQ-009 sort_in SHALL update only in RECV and SHALL hold stable from entry to SORT until the next RECV entry.
REQ-010 sort_start SHALL pulse exactly once, in the cycle after the rx_valid carrying the final byte.
REQ-011 sort_out SHALL be captured into an internal register on the sort_done cycle.
REQ-012 The first tx_valid SHALL assert in the cycle after sort_done.
REQ-013 Transmission SHALL send key 0 first, each key MSB byte first.
REQ-014 tx_valid/tx_data SHALL hold stable until the cycle tx_ready=1; the next byte SHALL be presented in the following cycle.
REQ-015 tx_valid SHALL be low outside SEND.
REQ-016 rx_valid in SORT or SEND SHALL drop the byte and set overrun; only reset clears overrun.
REQ-017 sort_done outside SORT SHALL be ignored.
REQ-018 On the final accepted byte, seq_cnt SHALL increment.
REQ-019 If the increment reaches NUM_SEQ, seq_cnt SHALL wrap to 0 in that same cycle and batch_done SHALL pulse.
REQ-020 Byte and key counters SHALL reset to 0 on every RECV and SEND entry.

Reset
REQ-021 Asserting rst SHALL immediately force state IDLE, including mid-operation.
REQ-022 Under rst, every output SHALL go to 0: tx_data, tx_valid, sort_start, sort_in, seq_cnt, batch_done, overrun, rx_led, tx_led.
REQ-023 Under rst, all counters and capture registers SHALL clear to 0.
REQ-024 A sequence in flight when rst asserts SHALL be discarded with no partial output.

Configuration
REQ-025 With SORT_CKSUM_EN defined, SEND SHALL append one extra byte after the last data byte: the XOR of all transmitted data bytes, using the same handshake.
REQ-026 Without SORT_CKSUM_EN, exactly DEPTH*WIDTH/8 bytes SHALL be sent per sequence.

Structure
REQ-027 Package sort_ctrl_pkg SHALL hold:
- the state enum;
- BYTES_PER_WORD = WIDTH/8;
- the default WIDTH, DEPTH and NUM_SEQ constants.
REQ-028 The byte-to-key shift/pack logic SHALL be the sub-module sort_word_pack.
REQ-029 The FSM, counters and TX serialiser SHALL remain in sort_seq_ctrl.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=32, DEPTH=8 unless stated):
- 32 bytes encoding keys 8..1 -> sort_in key0=0x00000008; one sort_start pulse; model sorted 1..8 -> 32 tx bytes, first 00 00 00 01.
- tx_ready held low 5 cycles -> tx_valid/tx_data unchanged; byte 1 presented the cycle after acceptance.
- rx byte 0xAA during SORT -> overrun=1; output stream unchanged.
- 10 sequences with NUM_SEQ=10 -> seq_cnt 1..9 then 0; batch_done exactly once.
- rst asserted after 17 rx bytes -> all outputs 0 immediately; a fresh 32-byte sequence then sorts correctly.
- SORT_CKSUM_EN defined, sorted keys 1..8 -> 33rd byte = 0x08 (XOR of data bytes).
